// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// map and the CPU interrupt vector.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StService = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_MASK      = 2'd0;
  localparam logic [1:0] ADDR_PENDING   = 2'd1;
  localparam logic [1:0] ADDR_TIMER_CMP = 2'd2;
  localparam logic [1:0] ADDR_STATUS    = 2'd3;

  // Address the CPU jumps to when irq is taken.
  localparam int unsigned IRQ_VECTOR = 356;

  // STATUS layout: bit4 in_service, bits3:0 irq_id.
  function automatic logic [31:0] status_word(input logic in_service, input logic [3:0] id);
    return {27'd0, in_service, id};
  endfunction

endpackage

// File: rtl/int_ctrl_sync.sv
// One-bit two-flop synchronizer followed by a rising-edge detector.
// Reset value 0 makes a line already high at reset release look like an edge.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronize the raw line and remember the previous synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], src_i};
      prev_q <= sync_q[1];
    end
  end

  assign edge_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected sources, MASK/PENDING registers,
// lowest-index-first priority, single-cycle irq pulse, eret-terminated service.
// Optional feature: define INT_CTRL_TIMER_EN to add a compare timer acting as
// an extra lowest-priority source at index N_SRC.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  output logic             irq,
  output logic [3:0]       irq_id,
  input  logic             eret,
  input  logic             bus_we,
  input  logic [1:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata
);

`ifdef INT_CTRL_TIMER_EN
  localparam int unsigned W = N_SRC + 1;
`else
  localparam int unsigned W = N_SRC;
`endif

  logic [N_SRC-1:0] src_edge;
  logic [W-1:0]     set_vec, clr_vec, active;
  logic [W-1:0]     mask_q, mask_d, pending_q, pending_d;
  logic [31:0]      cmp_rd;
  logic [3:0]       next_id;
  logic             mask_wr, pend_wr, cmp_wr, eret_clr;
  state_e           state_q;
  logic             irq_q;
  logic [3:0]       irq_id_q;
  logic             unused_wdata;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    int_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .src_i (src[g]),
      .edge_o(src_edge[g])
    );
  end

  assign mask_wr  = bus_we && (bus_addr == ADDR_MASK);
  assign pend_wr  = bus_we && (bus_addr == ADDR_PENDING);
  assign cmp_wr   = bus_we && (bus_addr == ADDR_TIMER_CMP);
  assign eret_clr = (state_q == StService) && eret;
  assign unused_wdata = ^bus_wdata;

`ifdef INT_CTRL_TIMER_EN
  logic [31:0] cmp_q, cnt_q, cnt_d;
  logic        timer_hit;

  assign timer_hit = (cmp_q != 32'd0) && (cnt_q == cmp_q);

  // Free-running counter; wraps on compare match, restarts on TIMER_CMP write.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (cmp_wr || timer_hit) begin
      cnt_d = 32'd0;
    end
  end

  // Timer compare and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= 32'd0;
      cnt_q <= 32'd0;
    end else begin
      if (cmp_wr) begin
        cmp_q <= bus_wdata;
      end
      cnt_q <= cnt_d;
    end
  end

  assign set_vec = {timer_hit, src_edge};
  assign cmp_rd  = cmp_q;
`else
  assign set_vec = src_edge;
  assign cmp_rd  = 32'd0;
`endif

  // Pending: write-1-to-clear and eret clear, a same-cycle edge wins.
  always_comb begin
    clr_vec = '0;
    if (pend_wr) begin
      clr_vec = bus_wdata[W-1:0];
    end
    if (eret_clr) begin
      clr_vec = clr_vec | (W'(1) << irq_id_q);
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
    mask_d    = mask_wr ? bus_wdata[W-1:0] : mask_q;
  end

  // MASK and PENDING registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
    end
  end

  assign active = pending_q & mask_q;

  // Lowest set index wins; the timer sits at the top index so it loses ties.
  always_comb begin
    next_id = 4'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (active[i]) begin
        next_id = 4'(i);
      end
    end
  end

  // Service FSM with registered irq and irq_id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      irq_q    <= 1'b0;
      irq_id_q <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          irq_q <= 1'b0;
          if (|active) begin
            irq_id_q <= next_id;
            irq_q    <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          irq_q   <= 1'b0;
          state_q <= StService;
        end
        StService: begin
          irq_q <= 1'b0;
          if (eret) begin
            state_q <= StIdle;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

  // Combinational register read mux.
  always_comb begin
    bus_rdata = 32'd0;
    unique case (bus_addr)
      ADDR_MASK:      bus_rdata = 32'(mask_q);
      ADDR_PENDING:   bus_rdata = 32'(pending_q);
      ADDR_TIMER_CMP: bus_rdata = cmp_rd;
      ADDR_STATUS:    bus_rdata = status_word(state_q != StIdle, irq_id_q);
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: expected irq_id values are queued as
// stimulus is driven and popped by a monitor whenever irq pulses.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int unsigned N_SRC = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_SRC-1:0] src = '0;
  logic             irq;
  logic [3:0]       irq_id;
  logic             eret = 1'b0;
  logic             bus_we = 1'b0;
  logic [1:0]       bus_addr = 2'd0;
  logic [31:0]      bus_wdata = 32'd0;
  logic [31:0]      bus_rdata;

  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];
  logic       prev_irq = 1'b0;

  always #5 clk = ~clk;

  int_ctrl #(.N_SRC(N_SRC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src      (src),
    .irq      (irq),
    .irq_id   (irq_id),
    .eret     (eret),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  // Scoreboard monitor: every irq pulse must match the oldest expected id.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_irq <= 1'b0;
    end else begin
      if (irq === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_irq: irq_id=%0d, no irq expected", irq_id);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (irq_id !== e) begin
            bad++;
            $display("FAIL irq_id: got %0d want %0d", irq_id, e);
          end
        end
        total++;
        if (prev_irq === 1'b1) begin
          bad++;
          $display("FAIL irq_width: irq high on two consecutive cycles, want one");
        end
      end
      prev_irq <= irq;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a;
    #1 d = bus_rdata;
  endtask

  task automatic pulse_src(input logic [N_SRC-1:0] m);
    @(negedge clk);
    src = src | m;
    @(negedge clk);
    src = src & ~m;
  endtask

  task automatic do_eret;
    @(negedge clk);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
  endtask

  task automatic wait_irq(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (irq !== 1'b1 && n < 40);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: irq=%b after %0d cycles, want 1", tag, irq, n);
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst_n = 1'b0;
    bus_addr = ADDR_STATUS;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    total++; if (irq_id !== 4'd0) begin bad++; $display("FAIL rst_irq_id: got %0d want 0", irq_id); end
    total++; if (bus_rdata !== 32'd0) begin bad++; $display("FAIL rst_status: got %h want 0", bus_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(ADDR_MASK, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL rst_mask: got %h want 0", r); end
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL rst_pending: got %h want 0", r); end
    bus_read(ADDR_TIMER_CMP, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL rst_timer_cmp: got %h want 0", r); end
  endtask

  // One source, exact latency: irq seen after the 4th edge from the src rise.
  task automatic test_single;
    logic [31:0] r;
    bus_write(ADDR_MASK, 32'h01);
    exp_q.push_back(4'd0);
    pulse_src(8'h01);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_early: cycle %0d irq=%b want 0", k, irq); end
    end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL single_latency: irq=%b want 1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_drop: irq=%b want 0", irq); end
    bus_addr = ADDR_STATUS;
    #1;
    total++; if (bus_rdata !== 32'h10) begin bad++; $display("FAIL single_status: got %h want 10", bus_rdata); end
    do_eret;
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL single_pend_clr: got %h want 0", r); end
    bus_read(ADDR_STATUS, r);
    total++; if (r !== 32'h00) begin bad++; $display("FAIL single_status_idle: got %h want 00", r); end
  endtask

  // Two simultaneous sources: lower index first, one IDLE cycle before the next.
  task automatic test_priority;
    int n;
    bus_write(ADDR_MASK, 32'hFF);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd5);
    pulse_src(8'h24);
    wait_irq("prio_first", n);
    do_eret;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_gap: irq=%b want 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_second: irq=%b want 1", irq); end
    do_eret;
  endtask

  // Masked source stays pending, then unmasking issues it.
  task automatic test_masked;
    logic [31:0] r;
    int n;
    bus_write(ADDR_MASK, 32'h00);
    pulse_src(8'h08);
    repeat (5) begin
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL masked_irq: irq=%b want 0", irq); end
    end
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'h08) begin bad++; $display("FAIL masked_pending: got %h want 08", r); end
    exp_q.push_back(4'd3);
    bus_write(ADDR_MASK, 32'h08);
    wait_irq("masked_unmask", n);
    do_eret;
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'h00) begin bad++; $display("FAIL masked_pend_clr: got %h want 00", r); end
  endtask

  // Events during SERVICE: new source, MASK change, W1C; stray eret in IDLE.
  task automatic test_service;
    logic [31:0] r;
    int n;
    bus_write(ADDR_MASK, 32'hFF);
    exp_q.push_back(4'd6);
    pulse_src(8'h40);
    wait_irq("svc_first", n);
    exp_q.push_back(4'd1);
    pulse_src(8'h02);
    bus_write(ADDR_MASK, 32'h00);
    bus_read(ADDR_STATUS, r);
    total++; if (r !== 32'h16) begin bad++; $display("FAIL svc_mask_change: got %h want 16", r); end
    bus_write(ADDR_PENDING, 32'h40);
    bus_read(ADDR_STATUS, r);
    total++; if (r !== 32'h16) begin bad++; $display("FAIL svc_w1c_no_end: got %h want 16", r); end
    bus_write(ADDR_MASK, 32'hFF);
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'h02) begin bad++; $display("FAIL svc_pending: got %h want 02", r); end
    do_eret;
    wait_irq("svc_second", n);
    do_eret;
    bus_read(ADDR_STATUS, r);
    total++; if (r !== 32'h01) begin bad++; $display("FAIL svc_status_after: got %h want 01", r); end
    do_eret;
    repeat (3) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL stray_eret_irq: irq=%b want 0", irq); end
    bus_read(ADDR_STATUS, r);
    total++; if (r !== 32'h01) begin bad++; $display("FAIL stray_eret_status: got %h want 01", r); end
  endtask

  // Edge and write-1-to-clear land on the same edge: the set must win.
  task automatic test_set_clear;
    logic [31:0] r;
    bus_write(ADDR_MASK, 32'h00);
    pulse_src(8'h01);
    bus_write(ADDR_PENDING, 32'h01);
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'h01) begin bad++; $display("FAIL set_wins: got %h want 01", r); end
    bus_write(ADDR_PENDING, 32'h01);
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'h00) begin bad++; $display("FAIL w1c: got %h want 00", r); end
  endtask

  task automatic test_timer;
    logic [31:0] r;
`ifdef INT_CTRL_TIMER_EN
    int n;
    bus_write(ADDR_MASK, 32'(1) << N_SRC);
    exp_q.push_back(4'(N_SRC));
    exp_q.push_back(4'(N_SRC));
    bus_write(ADDR_TIMER_CMP, 32'd10);
    bus_read(ADDR_TIMER_CMP, r);
    total++; if (r !== 32'd10) begin bad++; $display("FAIL timer_cmp_rd: got %0d want 10", r); end
    wait_irq("timer_first", n);
    do_eret;
    wait_irq("timer_second", n);
    total++; if (n + 2 !== 11) begin bad++; $display("FAIL timer_period: got %0d want 11", n + 2); end
    do_eret;
    bus_write(ADDR_MASK, 32'h0);
    bus_write(ADDR_TIMER_CMP, 32'd0);
    bus_write(ADDR_PENDING, 32'(1) << N_SRC);
    bus_write(ADDR_MASK, 32'(1) << N_SRC);
    repeat (30) @(negedge clk);
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL timer_off_pending: got %h want 0", r); end
    bus_write(ADDR_MASK, 32'h0);
`else
    bus_write(ADDR_TIMER_CMP, 32'd10);
    bus_read(ADDR_TIMER_CMP, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL timer_absent_rd: got %0d want 0", r); end
`endif
  endtask

  // Reset in ISSUE and in SERVICE; a line held high across reset release.
  task automatic test_reset_mid;
    logic [31:0] r;
    int n;
    bus_write(ADDR_MASK, 32'hFF);
    exp_q.push_back(4'd7);
    pulse_src(8'h80);
    wait_irq("rst_issue", n);
    #2 rst_n = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_issue_irq: irq=%b want 0", irq); end
    bus_addr = ADDR_STATUS;
    #1;
    total++; if (bus_rdata !== 32'd0) begin bad++; $display("FAIL rst_issue_status: got %h want 0", bus_rdata); end
    src = 8'h10;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'h10) begin bad++; $display("FAIL rst_src_high: got %h want 10", r); end
    src = 8'h00;
    exp_q.push_back(4'd4);
    bus_write(ADDR_MASK, 32'hFF);
    wait_irq("rst_service", n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 bus_addr = ADDR_STATUS;
    #1;
    total++; if (bus_rdata !== 32'd0) begin bad++; $display("FAIL rst_svc_status: got %h want 0", bus_rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_svc_irq: irq=%b want 0", irq); end
    bus_addr = ADDR_MASK;
    #1;
    total++; if (bus_rdata !== 32'd0) begin bad++; $display("FAIL rst_svc_mask: got %h want 0", bus_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(ADDR_PENDING, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL rst_svc_pending: got %h want 0", r); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_masked;
    test_service;
    test_set_clear;
    test_timer;
    test_reset_mid;
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_irq: %0d expected irq(s) never seen, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
